// File: rtl/bus_mailbox.sv
// CPU-bus mailbox: an 8-bit register window over a host-to-CPU FIFO and a
// CPU-to-host FIFO, with sticky error flags and a level interrupt.
module bus_mailbox #(
  parameter int FIFO_BITS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bus_clken,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] rs,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq_n,
  input  logic [7:0] h2c_data,
  input  logic       h2c_valid,
  output logic       h2c_ready,
  output logic [7:0] c2h_data,
  output logic       c2h_valid,
  input  logic       c2h_ready
);

  localparam int                   DEPTH    = 2 ** FIFO_BITS;
  localparam logic [FIFO_BITS-1:0] PTR_ONE  = FIFO_BITS'(1);
  localparam logic [FIFO_BITS:0]   CNT_ONE  = (FIFO_BITS + 1)'(1);
  localparam logic [FIFO_BITS:0]   CNT_ZERO = (FIFO_BITS + 1)'(0);
  localparam logic [FIFO_BITS:0]   CNT_FULL = (FIFO_BITS + 1)'(DEPTH);

  localparam logic [1:0] RS_DATA   = 2'd0;
  localparam logic [1:0] RS_STATUS = 2'd1;
  localparam logic [1:0] RS_CTRL   = 2'd2;
  localparam logic [1:0] RS_COUNT  = 2'd3;

  logic [7:0]           h2c_mem_q [DEPTH];
  logic [7:0]           c2h_mem_q [DEPTH];

  logic [FIFO_BITS-1:0] h2c_wptr_q, h2c_wptr_d, h2c_rptr_q, h2c_rptr_d;
  logic [FIFO_BITS-1:0] c2h_wptr_q, c2h_wptr_d, c2h_rptr_q, c2h_rptr_d;
  logic [FIFO_BITS:0]   h2c_cnt_q, h2c_cnt_d, c2h_cnt_q, c2h_cnt_d;
  logic [1:0]           ctrl_q, ctrl_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d;
  logic [7:0]           dout_q, dout_d;
  logic                 irq_n_q, irq_n_d;

  logic bus_rd_s, bus_wr_s;
  logic h2c_empty_s, h2c_full_s, c2h_empty_s, c2h_full_s;
  logic cpu_pop_s, unf_evt_s, host_push_s;
  logic cpu_push_s, ovf_evt_s, host_pop_s;
  logic clr_s, irq_cond_s;
  logic [7:0] status_s;

  assign bus_rd_s    = cs && bus_clken && !we;
  assign bus_wr_s    = cs && bus_clken && we;

  assign h2c_empty_s = (h2c_cnt_q == CNT_ZERO);
  assign h2c_full_s  = (h2c_cnt_q == CNT_FULL);
  assign c2h_empty_s = (c2h_cnt_q == CNT_ZERO);
  assign c2h_full_s  = (c2h_cnt_q == CNT_FULL);

  // Every FIFO decision uses pre-edge state, so a push into a full FIFO is
  // refused even when a pop completes in the same cycle.
  assign cpu_pop_s   = bus_rd_s && (rs == RS_DATA) && !h2c_empty_s;
  assign unf_evt_s   = bus_rd_s && (rs == RS_DATA) && h2c_empty_s;
  assign host_push_s = h2c_valid && !h2c_full_s;
  assign cpu_push_s  = bus_wr_s && (rs == RS_DATA) && !c2h_full_s;
  assign ovf_evt_s   = bus_wr_s && (rs == RS_DATA) && c2h_full_s;
  assign host_pop_s  = c2h_ready && !c2h_empty_s;
  assign clr_s       = bus_wr_s && (rs == RS_CTRL) && din[7];

  assign irq_cond_s  = (ctrl_q[0] && !h2c_empty_s) || (ctrl_q[1] && c2h_empty_s);
  assign status_s    = {irq_cond_s, 3'b000, unf_q, ovf_q, !c2h_full_s, !h2c_empty_s};

  assign h2c_ready   = !h2c_full_s;
  assign c2h_valid   = !c2h_empty_s;
  assign c2h_data    = c2h_mem_q[c2h_rptr_q];
  assign dout        = dout_q;
  assign irq_n       = irq_n_q;

  // FIFO storage writes; contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (host_push_s) begin
      h2c_mem_q[h2c_wptr_q] <= h2c_data;
    end
    if (cpu_push_s) begin
      c2h_mem_q[c2h_wptr_q] <= din;
    end
  end

  // Pointer and occupancy next-state for both FIFOs.
  always_comb begin
    h2c_wptr_d = h2c_wptr_q;
    h2c_rptr_d = h2c_rptr_q;
    h2c_cnt_d  = h2c_cnt_q;
    c2h_wptr_d = c2h_wptr_q;
    c2h_rptr_d = c2h_rptr_q;
    c2h_cnt_d  = c2h_cnt_q;

    if (host_push_s) begin
      h2c_wptr_d = h2c_wptr_q + PTR_ONE;
    end else begin
      h2c_wptr_d = h2c_wptr_q;
    end
    if (cpu_pop_s) begin
      h2c_rptr_d = h2c_rptr_q + PTR_ONE;
    end else begin
      h2c_rptr_d = h2c_rptr_q;
    end
    case ({host_push_s, cpu_pop_s})
      2'b10:   h2c_cnt_d = h2c_cnt_q + CNT_ONE;
      2'b01:   h2c_cnt_d = h2c_cnt_q - CNT_ONE;
      default: h2c_cnt_d = h2c_cnt_q;
    endcase

    if (cpu_push_s) begin
      c2h_wptr_d = c2h_wptr_q + PTR_ONE;
    end else begin
      c2h_wptr_d = c2h_wptr_q;
    end
    if (host_pop_s) begin
      c2h_rptr_d = c2h_rptr_q + PTR_ONE;
    end else begin
      c2h_rptr_d = c2h_rptr_q;
    end
    case ({cpu_push_s, host_pop_s})
      2'b10:   c2h_cnt_d = c2h_cnt_q + CNT_ONE;
      2'b01:   c2h_cnt_d = c2h_cnt_q - CNT_ONE;
      default: c2h_cnt_d = c2h_cnt_q;
    endcase
  end

  // Register-file next-state: control, sticky flags, read data, interrupt.
  always_comb begin
    ctrl_d  = ctrl_q;
    dout_d  = dout_q;
    irq_n_d = !irq_cond_s;

    if (bus_wr_s && (rs == RS_CTRL)) begin
      ctrl_d = din[1:0];
    end else begin
      ctrl_d = ctrl_q;
    end

    // A fresh event outranks a clear arriving in the same cycle.
    ovf_d = (ovf_q && !clr_s) || ovf_evt_s;
    unf_d = (unf_q && !clr_s) || unf_evt_s;

    if (bus_rd_s) begin
      case (rs)
        RS_DATA:   dout_d = h2c_empty_s ? 8'h00 : h2c_mem_q[h2c_rptr_q];
        RS_STATUS: dout_d = status_s;
        RS_CTRL:   dout_d = {6'b000000, ctrl_q};
        RS_COUNT:  dout_d = 8'(h2c_cnt_q);
        default:   dout_d = 8'h00;
      endcase
    end else begin
      dout_d = dout_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h2c_wptr_q <= {FIFO_BITS{1'b0}};
      h2c_rptr_q <= {FIFO_BITS{1'b0}};
      h2c_cnt_q  <= CNT_ZERO;
      c2h_wptr_q <= {FIFO_BITS{1'b0}};
      c2h_rptr_q <= {FIFO_BITS{1'b0}};
      c2h_cnt_q  <= CNT_ZERO;
      ctrl_q     <= 2'b00;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      dout_q     <= 8'h00;
      irq_n_q    <= 1'b1;
    end else begin
      h2c_wptr_q <= h2c_wptr_d;
      h2c_rptr_q <= h2c_rptr_d;
      h2c_cnt_q  <= h2c_cnt_d;
      c2h_wptr_q <= c2h_wptr_d;
      c2h_rptr_q <= c2h_rptr_d;
      c2h_cnt_q  <= c2h_cnt_d;
      ctrl_q     <= ctrl_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      dout_q     <= dout_d;
      irq_n_q    <= irq_n_d;
    end
  end

endmodule

// File: tb/tb_bus_mailbox.sv
// Bench for bus_mailbox: directed scenarios plus a randomized run, all checked
// against a queue-based model of the mailbox.
module tb_bus_mailbox;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bus_clken = 1'b0;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic [1:0] rs = 2'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       irq_n;
  logic [7:0] h2c_data = 8'h00;
  logic       h2c_valid = 1'b0;
  logic       h2c_ready;
  logic [7:0] c2h_data;
  logic       c2h_valid;
  logic       c2h_ready = 1'b0;

  int total = 0;
  int bad = 0;

  // model state
  logic [7:0] m_h2c[$];
  logic [7:0] m_c2h[$];
  logic [1:0] m_ctrl;
  logic       m_ovf, m_unf, m_irq_n;
  logic [7:0] m_dout;

  bus_mailbox #(.FIFO_BITS(3)) dut (
    .clk(clk), .reset(reset), .bus_clken(bus_clken), .cs(cs), .we(we),
    .rs(rs), .din(din), .dout(dout), .irq_n(irq_n),
    .h2c_data(h2c_data), .h2c_valid(h2c_valid), .h2c_ready(h2c_ready),
    .c2h_data(c2h_data), .c2h_valid(c2h_valid), .c2h_ready(c2h_ready)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_h2c.delete();
    m_c2h.delete();
    m_ctrl  = 2'b00;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_irq_n = 1'b1;
    m_dout  = 8'h00;
  endtask

  // One clock cycle of stimulus; the model advances from its pre-edge state.
  task automatic step(input logic ce, input logic cs_v, input logic we_v,
                      input logic [1:0] rs_v, input logic [7:0] din_v,
                      input logic hv, input logic [7:0] hd, input logic cr);
    int  hs = m_h2c.size();
    int  cn = m_c2h.size();
    logic acc = ce && cs_v;
    logic cond = (m_ctrl[0] && hs > 0) || (m_ctrl[1] && cn == 0);
    logic do_pop = 1'b0;
    logic do_cpush = 1'b0;
    logic do_hpush = hv && (hs < 8);
    logic do_hpop = cr && (cn > 0);
    bus_clken = ce; cs = cs_v; we = we_v; rs = rs_v; din = din_v;
    h2c_valid = hv; h2c_data = hd; c2h_ready = cr;
    if (acc && !we_v) begin
      case (rs_v)
        2'd0: if (hs > 0) begin m_dout = m_h2c[0]; do_pop = 1'b1; end
              else begin m_dout = 8'h00; m_unf = 1'b1; end
        2'd1: m_dout = {cond, 3'b000, m_unf, m_ovf, cn < 8, hs > 0};
        2'd2: m_dout = {6'b000000, m_ctrl};
        default: m_dout = 8'(hs);
      endcase
    end
    if (acc && we_v) begin
      if (rs_v == 2'd0) begin
        if (cn < 8) do_cpush = 1'b1; else m_ovf = 1'b1;
      end else if (rs_v == 2'd2) begin
        m_ctrl = din_v[1:0];
        if (din_v[7]) begin m_ovf = 1'b0; m_unf = 1'b0; end
      end
    end
    if (do_pop) void'(m_h2c.pop_front());
    if (do_hpush) m_h2c.push_back(hd);
    if (do_hpop) void'(m_c2h.pop_front());
    if (do_cpush) m_c2h.push_back(din_v);
    m_irq_n = !cond;
    @(posedge clk);
    #1;
    bus_clken = 1'b0; cs = 1'b0; we = 1'b0; h2c_valid = 1'b0; c2h_ready = 1'b0;
  endtask

  task automatic rd(input logic [1:0] r);
    step(1'b1, 1'b1, 1'b0, r, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [1:0] r, input logic [7:0] d);
    step(1'b1, 1'b1, 1'b1, r, d, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic hpush(input logic [7:0] d);
    step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, d, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got %h want 00", dout); end
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL reset_irq got %b want 1", irq_n); end
    total++; if (h2c_ready !== 1'b1) begin bad++; $display("FAIL reset_h2c_ready got %b want 1", h2c_ready); end
    total++; if (c2h_valid !== 1'b0) begin bad++; $display("FAIL reset_c2h_valid got %b want 0", c2h_valid); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_h2c_basic();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    for (int i = 0; i < 3; i++) hpush(exp_b[i]);
    rd(2'd3);
    total++; if (dout !== 8'h03) begin bad++; $display("FAIL basic_count got %h want 03", dout); end
    for (int i = 0; i < 3; i++) begin
      rd(2'd0);
      total++; if (dout !== exp_b[i]) begin bad++; $display("FAIL basic_data%0d got %h want %h", i, dout, exp_b[i]); end
    end
    rd(2'd1);
    total++; if (dout[0] !== 1'b0) begin bad++; $display("FAIL basic_status0 got %b want 0", dout[0]); end
  endtask

  task automatic test_h2c_full();
    for (int i = 0; i < 9; i++) begin
      hpush(8'(8'h40 + i));
      if (i == 7) begin
        total++; if (h2c_ready !== 1'b0) begin bad++; $display("FAIL full_ready got %b want 0", h2c_ready); end
      end
    end
    rd(2'd3);
    total++; if (dout !== 8'h08) begin bad++; $display("FAIL full_count got %h want 08", dout); end
    for (int i = 0; i < 8; i++) begin
      rd(2'd0);
      total++; if (dout !== 8'(8'h40 + i)) begin bad++; $display("FAIL full_drain%0d got %h want %h", i, dout, 8'(8'h40 + i)); end
    end
  endtask

  task automatic test_c2h_overflow();
    wr(2'd2, 8'h80);
    for (int i = 0; i < 9; i++) wr(2'd0, 8'(8'hA0 + i));
    rd(2'd1);
    total++; if (dout !== 8'h04) begin bad++; $display("FAIL ovf_status got %h want 04", dout); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (c2h_valid !== 1'b1 || c2h_data !== 8'(8'hA0 + i)) begin
        bad++; $display("FAIL ovf_pop%0d got v=%b d=%h want v=1 d=%h", i, c2h_valid, c2h_data, 8'(8'hA0 + i));
      end
      step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b1);
    end
    total++; if (c2h_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got %b want 0", c2h_valid); end
    wr(2'd2, 8'h80);
  endtask

  task automatic test_underflow();
    wr(2'd2, 8'h02);
    rd(2'd2);
    wr(2'd2, 8'h00);
    total++; if (dout !== 8'h02) begin bad++; $display("FAIL unf_hold got %h want 02", dout); end
    rd(2'd0);
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL unf_data got %h want 00", dout); end
    rd(2'd1);
    total++; if (dout !== 8'h0A) begin bad++; $display("FAIL unf_status got %h want 0a", dout); end
    wr(2'd2, 8'h80);
    rd(2'd1);
    total++; if (dout[3] !== 1'b0) begin bad++; $display("FAIL unf_clear got %b want 0", dout[3]); end
    rd(2'd2);
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL unf_ctrl got %h want 00", dout); end
  endtask

  task automatic test_irq();
    wr(2'd2, 8'h01);
    hpush(8'h5A);
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL irq_push_cycle got %b want 1", irq_n); end
    step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0);
    total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL irq_low got %b want 0", irq_n); end
    rd(2'd0);
    total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL irq_read_cycle got %b want 0", irq_n); end
    step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0);
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL irq_high got %b want 1", irq_n); end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) hpush(8'(8'h70 + i));
    wr(2'd0, 8'hC1);
    wr(2'd0, 8'hC2);
    wr(2'd2, 8'h01);
    step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0);
    total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL mid_pre_irq got %b want 0", irq_n); end
    reset = 1'b1;
    #1;
    total++; if (c2h_valid !== 1'b0) begin bad++; $display("FAIL mid_c2h_valid got %b want 0", c2h_valid); end
    total++; if (h2c_ready !== 1'b1) begin bad++; $display("FAIL mid_h2c_ready got %b want 1", h2c_ready); end
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL mid_irq got %b want 1", irq_n); end
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    rd(2'd3);
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL mid_count got %h want 00", dout); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [1:0] r = 2'($urandom_range(0, 3));
      logic [7:0] d = 8'($urandom);
      if (r == 2'd2 && ($urandom_range(0, 3) != 0)) d[7] = 1'b0;
      step(1'($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom), r, d,
           1'($urandom), 8'($urandom), 1'($urandom_range(0, 2) == 0));
      total++; if (dout !== m_dout) begin bad++; $display("FAIL rnd_dout@%0d got %h want %h", n, dout, m_dout); end
      total++; if (irq_n !== m_irq_n) begin bad++; $display("FAIL rnd_irq@%0d got %b want %b", n, irq_n, m_irq_n); end
      total++; if (h2c_ready !== (m_h2c.size() < 8)) begin bad++; $display("FAIL rnd_h2c_ready@%0d got %b want %b", n, h2c_ready, m_h2c.size() < 8); end
      total++; if (c2h_valid !== (m_c2h.size() > 0)) begin bad++; $display("FAIL rnd_c2h_valid@%0d got %b want %b", n, c2h_valid, m_c2h.size() > 0); end
      if (m_c2h.size() > 0) begin
        total++; if (c2h_data !== m_c2h[0]) begin bad++; $display("FAIL rnd_c2h_data@%0d got %h want %h", n, c2h_data, m_c2h[0]); end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_h2c_basic();
    test_h2c_full();
    test_c2h_overflow();
    test_underflow();
    test_irq();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_mailbox.md
BUS_MAILBOX -- requirements
Module: bus_mailbox

Interface
REQ-001 Parameter: FIFO_BITS, default 3; each FIFO depth is 2**FIFO_BITS entries (8 by default).
REQ-002 Port: clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: bus_clken  input  1  one-cycle strobe marking the CPU bus access cycle (peripheral clock enable).
REQ-005 Port: cs  input  1  chip select, decoded from the CPU address.
REQ-006 Port: we  input  1  1 = CPU write, 0 = CPU read.
REQ-007 Port: rs  input  2  register select (CPU address bits 1:0).
REQ-008 Port: din  input  8  CPU write data.
REQ-009 Port: dout  output  8  registered CPU read data.
REQ-010 Port: irq_n  output  1  active-low interrupt request, registered.
REQ-011 Port: h2c_data  input  8  host-to-CPU FIFO push data.
REQ-012 Port: h2c_valid  input  1  host push request.
REQ-013 Port: h2c_ready  output  1  host-to-CPU FIFO not full.
REQ-014 Port: c2h_data  output  8  head entry of the CPU-to-host FIFO.
REQ-015 Port: c2h_valid  output  1  CPU-to-host FIFO not empty.
REQ-016 Port: c2h_ready  input  1  host pop acknowledge.

Function
REQ-017 A bus access SHALL occur only in a cycle where cs && bus_clken is true; at most one register action takes place per strobe.
REQ-018 Register map SHALL be:
- rs=0 DATA: a read pops the h2c FIFO; a write pushes to the c2h FIFO.
- rs=1 STATUS: read-only; writes are ignored.
- rs=2 CONTROL: read/write.
- rs=3 COUNT: read-only; writes are ignored.
REQ-019 STATUS bits SHALL be:
- bit0 = h2c not empty
- bit1 = c2h not full
- bit2 = overflow (sticky)
- bit3 = underflow (sticky)
- bit7 = interrupt active
- all other bits read 0
REQ-020 CONTROL bits SHALL be:
- bit0 = interrupt enable, h2c not empty
- bit1 = interrupt enable, c2h empty
- bits 6:2 read 0
- bit7: writing 1 clears both sticky flags; bit7 is not stored and reads 0
REQ-021 COUNT SHALL read the h2c occupancy (0..2**FIFO_BITS), zero-extended to 8 bits.
REQ-022 On a read access, dout SHALL be loaded at that clock edge with the value from before the access, and SHALL hold until the next read access; write accesses SHALL NOT change dout.
REQ-023 A DATA read while h2c is empty SHALL return 0x00, set underflow, and leave the pointers unchanged.
REQ-024 A DATA write while c2h is full SHALL discard the data and set overflow.
REQ-025 The host push SHALL occur when h2c_valid && h2c_ready.
REQ-026 The host pop SHALL occur when c2h_valid && c2h_ready.
REQ-027 h2c_ready, c2h_valid and c2h_data SHALL be derived from registered FIFO state only, with no same-cycle bypass.
REQ-028 FIFO pointers SHALL be FIFO_BITS wide and wrap modulo 2**FIFO_BITS; occupancy counters SHALL be FIFO_BITS+1 wide.
REQ-029 Simultaneous push and pop on the same FIFO SHALL both complete and leave the occupancy unchanged.
REQ-030 With h2c full, a CPU pop and a host push requested in the same cycle: the pop completes, the push is not accepted (h2c_ready is 0), and the occupancy drops by 1.
REQ-031 With h2c empty, a CPU pop and a host push in the same cycle: the pop underflows (0x00, underflow set) and the push is stored.
REQ-032 If a sticky-clear write coincides with a new overflow or underflow event, the new event SHALL win and the flag SHALL remain set.
REQ-033 irq_n SHALL be registered as:
- NOT((CONTROL bit0 && h2c not empty) || (CONTROL bit1 && c2h empty))
- evaluated on the current state, so it updates one cycle after the state changes.

Reset
REQ-034 Reset SHALL set:
- both FIFOs empty, with pointers and counts = 0
- dout = 0x00
- CONTROL = 0x00
- sticky flags = 0
- irq_n = 1
- h2c_ready = 1
- c2h_valid = 0
REQ-035 Reset asserted in the middle of an operation SHALL discard all FIFO contents immediately; FIFO RAM contents need not be cleared.
REQ-036 No bus access or host push/pop SHALL take effect while reset is asserted.

Verification
REQ-037 Host pushes 0x11, 0x22, 0x33 -> COUNT reads 0x03; three DATA reads return 0x11, 0x22, 0x33; STATUS bit0 = 0 afterwards.
REQ-038 Host pushes 9 bytes with FIFO_BITS=3 -> h2c_ready is 0 after the 8th; the 9th is not accepted; COUNT = 0x08.
REQ-039 CPU writes 9 bytes to DATA with c2h_ready=0 -> STATUS reads 0x04 (overflow set, bit1 = 0); releasing c2h_ready yields the 8 first bytes in order, then c2h_valid = 0.
REQ-040 DATA read with h2c empty -> dout = 0x00 and STATUS bit3 = 1; a CONTROL write of 0x80 -> STATUS bit3 = 0 and CONTROL reads 0x00.
REQ-041 CONTROL = 0x01, then a host push -> irq_n goes low one cycle after the push cycle; a DATA read emptying the FIFO -> irq_n returns high one cycle later.
REQ-042 Reset asserted with both FIFOs partly full -> immediately c2h_valid = 0, h2c_ready = 1, irq_n = 1; after release, COUNT reads 0x00.
